// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, parity modes and a 2-of-3 vote helper.
// ST_BRK exists only when UART_RX_BREAK_DET_EN is defined.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
`ifdef UART_RX_BREAK_DET_EN
      , ST_BRK = 3'd5
`endif
   } uart_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every TICK_DIV clocks.
module uart_baud_tick #(
   parameter int unsigned SYS_CLK    = 50000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned DIV_RAW  = SYS_CLK / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver with majority voting, parity/stop checks and a one-deep
// ready/valid hold register. Optional break detection under UART_RX_BREAK_DET_EN.
module uart_rx_gen2
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLK    = 50000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rx_d,
   input  logic                 i_rx_ready,
   output logic [DATA_BITS-1:0] o_rx_d,
   output logic                 o_rx_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_break
);

   localparam int unsigned SC_W = $clog2(OVERSAMPLE);
   localparam int unsigned BC_W = 4;
   localparam logic [SC_W-1:0] S_MID0 = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0] S_MID1 = SC_W'(OVERSAMPLE / 2);
   localparam logic [SC_W-1:0] S_MID2 = SC_W'(OVERSAMPLE / 2 + 1);
   localparam logic [SC_W-1:0] S_LAST = SC_W'(OVERSAMPLE - 1);

   logic tick;

   uart_baud_tick #(
      .SYS_CLK   (SYS_CLK),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   logic [1:0]           sync_q, sync_d;
   logic                 prev_q, prev_d;
   uart_state_e          state_q, state_d;
   logic [SC_W-1:0]      sc_q, sc_d;
   logic [BC_W-1:0]      bc_q, bc_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           smp_q, smp_d;
   logic                 par_q, par_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 done_c;
   logic                 rx_s, maj_c, at_mid_c, at_wrap_c;
   logic                 frame_ferr_c, frame_perr_c, par_x_c;
`ifdef UART_RX_BREAK_DET_EN
   logic                 ones_q, ones_d;
   logic                 brk_c;
   logic                 brk_q, brk_d;
`endif

   logic [DATA_BITS-1:0] rx_d_q, rx_d_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   assign sync_d       = {sync_q[0], i_rx_d};
   assign rx_s         = sync_q[1];
   assign maj_c        = maj3(smp_q[0], smp_q[1], rx_s);
   assign at_mid_c     = (sc_q == S_MID2);
   assign at_wrap_c    = (sc_q == S_LAST);
   assign frame_ferr_c = ferr_acc_q | ~maj_c;
   assign par_x_c      = (^shift_q) ^ par_q;
   assign frame_perr_c = (PARITY == PAR_ODD)  ? ~par_x_c :
                         (PARITY == PAR_EVEN) ?  par_x_c : 1'b0;

   // Frame FSM: all decisions happen on oversampling ticks only.
   always_comb begin
      state_d    = state_q;
      sc_d       = sc_q;
      bc_d       = bc_q;
      shift_d    = shift_q;
      smp_d      = smp_q;
      par_d      = par_q;
      ferr_acc_d = ferr_acc_q;
      prev_d     = prev_q;
      done_c     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      ones_d     = ones_q;
      brk_c      = 1'b0;
`endif
      if (tick) begin
         prev_d = rx_s;
         sc_d   = at_wrap_c ? '0 : sc_q + SC_W'(1);
         if (sc_q == S_MID0) smp_d[0] = rx_s;
         if (sc_q == S_MID1) smp_d[1] = rx_s;
         case (state_q)
            ST_IDLE: begin
               sc_d = '0;
               if (!rx_s && prev_q) state_d = ST_START;
            end
            ST_START: begin
               if (at_mid_c && maj_c) begin
                  state_d = ST_IDLE;
               end else if (at_wrap_c) begin
                  state_d    = ST_DATA;
                  bc_d       = '0;
                  ferr_acc_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                  ones_d     = 1'b0;
`endif
               end
            end
            ST_DATA: begin
               if (at_mid_c) begin
                  shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                  ones_d  = ones_q | maj_c;
`endif
               end
               if (at_wrap_c) begin
                  if (bc_q == BC_W'(DATA_BITS - 1)) begin
                     bc_d    = '0;
                     state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  end else begin
                     bc_d = bc_q + BC_W'(1);
                  end
               end
            end
            ST_PAR: begin
               if (at_mid_c) begin
                  par_d  = maj_c;
`ifdef UART_RX_BREAK_DET_EN
                  ones_d = ones_q | maj_c;
`endif
               end
               if (at_wrap_c) state_d = ST_STOP;
            end
            ST_STOP: begin
               if (at_mid_c) begin
                  ferr_acc_d = frame_ferr_c;
`ifdef UART_RX_BREAK_DET_EN
                  ones_d     = ones_q | maj_c;
`endif
                  if (bc_q == BC_W'(STOP_BITS - 1)) begin
                     state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                     if (!(ones_q | maj_c)) begin
                        state_d = ST_BRK;
                        brk_c   = 1'b1;
                     end else begin
                        done_c = 1'b1;
                     end
`else
                     done_c = 1'b1;
`endif
                  end
               end
               if (at_wrap_c) bc_d = bc_q + BC_W'(1);
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BRK: begin
               sc_d = '0;
               if (rx_s) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // One-deep hold register; a frame arriving while full and not being drained is dropped.
   always_comb begin
      rx_d_d  = rx_d_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_d   = brk_c;
`endif
      if (valid_q && i_rx_ready) valid_d = 1'b0;
      if (done_c) begin
         if (!valid_q || i_rx_ready) begin
            rx_d_d  = shift_q;
            perr_d  = frame_perr_c;
            ferr_d  = frame_ferr_c;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= 2'b11;
         prev_q     <= 1'b1;
         state_q    <= ST_IDLE;
         sc_q       <= '0;
         bc_q       <= '0;
         shift_q    <= '0;
         smp_q      <= '0;
         par_q      <= 1'b0;
         ferr_acc_q <= 1'b0;
         rx_d_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         ones_q     <= 1'b0;
         brk_q      <= 1'b0;
`endif
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         state_q    <= state_d;
         sc_q       <= sc_d;
         bc_q       <= bc_d;
         shift_q    <= shift_d;
         smp_q      <= smp_d;
         par_q      <= par_d;
         ferr_acc_q <= ferr_acc_d;
         rx_d_q     <= rx_d_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
         ones_q     <= ones_d;
         brk_q      <= brk_d;
`endif
      end
   end

   assign o_rx_d       = rx_d_q;
   assign o_rx_valid   = valid_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = ferr_q;
   assign o_overrun    = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
   assign o_break      = brk_q;
`else
   assign o_break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Bench for uart_rx_gen2: 8N1 instance (A) and 7E2 instance (B), table vectors,
// random frames against a frame-level model, and hand-written corner sequences.
module tb_uart_rx_gen2;
   import uart_pkg::*;

   localparam int unsigned BIT_A = 32;
   localparam int unsigned BIT_B = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       rxa = 1'b1, rdya = 1'b1;
   logic [7:0] da;
   logic       va, pea, fea, ova, bka;
   logic       rxb = 1'b1, rdyb = 1'b1;
   logic [6:0] db;
   logic       vb, peb, feb, ovb, bkb;

   uart_rx_gen2 #(.SYS_CLK(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .i_rx_d(rxa), .i_rx_ready(rdya), .o_rx_d(da),
      .o_rx_valid(va), .o_parity_err(pea), .o_frame_err(fea), .o_overrun(ova), .o_break(bka));

   uart_rx_gen2 #(.SYS_CLK(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(8),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
      .clk(clk), .rst(rst), .i_rx_d(rxb), .i_rx_ready(rdyb), .o_rx_d(db),
      .o_rx_valid(vb), .o_parity_err(peb), .o_frame_err(feb), .o_overrun(ovb), .o_break(bkb));

   typedef struct packed { logic [8:0] d; logic pe; logic fe; } rec_t;
   rec_t qa[$], qb[$];
   int unsigned a_vcyc = 0, b_vcyc = 0, a_ovr = 0, b_ovr = 0, a_brk = 0, b_brk = 0;
   int unsigned total = 0, bad = 0;

   // Deliveries are recorded at the handshake as seen between clock edges.
   always @(negedge clk) begin
      if (!rst) begin
         if (va) a_vcyc++;
         if (vb) b_vcyc++;
         if (va && rdya) qa.push_back({9'(da), pea, fea});
         if (vb && rdyb) qb.push_back({9'(db), peb, feb});
         if (ova) a_ovr++;
         if (ovb) b_ovr++;
         if (bka) a_brk++;
         if (bkb) b_brk++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_a(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rxa = bits[i];
         cyc(BIT_A);
      end
      rxa = 1'b1;
   endtask

   task automatic drive_b(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rxb = bits[i];
         cyc(BIT_B);
      end
      rxb = 1'b1;
   endtask

   function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stp);
      return {6'b0, stp, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic s2);
      return {5'b0, s2, 1'b1, p, d, 1'b0};
   endfunction

   // Even parity: the data ones plus the parity bit must be an even count.
   function automatic logic even_perr(input logic [6:0] d, input logic p);
      return ((($countones(d) + int'(p)) % 2) == 1);
   endfunction

   function automatic rec_t pop_a();
      return (qa.size() > 0) ? qa.pop_front() : rec_t'('1);
   endfunction

   function automatic rec_t pop_b();
      return (qb.size() > 0) ? qb.pop_front() : rec_t'('1);
   endfunction

   typedef struct { logic [7:0] d; logic stp; logic [7:0] ed; logic ef; } va_t;
   typedef struct { logic [6:0] d; logic p; logic s2; logic [6:0] ed; logic ep; logic ef; } vb_t;

   initial begin
      va_t         ta[4];
      vb_t         tb[4];
      rec_t        r;
      int unsigned v0, o0, b0;
      logic [7:0]  rd;
      logic [6:0]  rd7;
      logic        rs, rp;

      ta[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      ta[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
      ta[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      ta[3] = '{8'h80, 1'b1, 8'h80, 1'b0};
      tb[0] = '{7'h35, 1'b1, 1'b1, 7'h35, 1'b1, 1'b0};
      tb[1] = '{7'h35, 1'b0, 1'b1, 7'h35, 1'b0, 1'b0};
      tb[2] = '{7'h01, 1'b1, 1'b1, 7'h01, 1'b0, 1'b0};
      tb[3] = '{7'h5A, 1'b0, 1'b0, 7'h5A, 1'b0, 1'b1};

      cyc(3);
      chk("rst_valid", 32'(va), 32'd0);
      chk("rst_data", 32'(da), 32'd0);
      chk("rst_flags", {28'd0, pea, fea, ova, bka}, 32'd0);
      chk("rst_state", 32'(u_a.state_q), 32'(ST_IDLE));
      rst = 1'b0;
      cyc(5);

      for (int i = 0; i < 4; i++) begin
         v0 = a_vcyc;
         drive_a(frame_a(ta[i].d, ta[i].stp), 10);
         cyc(2 * BIT_A);
         chk("a_tbl_count", 32'(qa.size()), 32'd1);
         r = pop_a();
         chk("a_tbl_data", 32'(r.d), 32'(ta[i].ed));
         chk("a_tbl_ferr", 32'(r.fe), 32'(ta[i].ef));
         chk("a_tbl_perr", 32'(r.pe), 32'd0);
         chk("a_tbl_vwidth", a_vcyc - v0, 32'd1);
      end

      for (int i = 0; i < 4; i++) begin
         drive_b(frame_b(tb[i].d, tb[i].p, tb[i].s2), 11);
         cyc(2 * BIT_B);
         chk("b_tbl_count", 32'(qb.size()), 32'd1);
         r = pop_b();
         chk("b_tbl_data", 32'(r.d), 32'(tb[i].ed));
         chk("b_tbl_perr", 32'(r.pe), 32'(tb[i].ep));
         chk("b_tbl_ferr", 32'(r.fe), 32'(tb[i].ef));
      end

      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0) || (rd == 8'h00);
         drive_a(frame_a(rd, rs), 10);
         cyc(2 * BIT_A);
         chk("a_rnd_count", 32'(qa.size()), 32'd1);
         r = pop_a();
         chk("a_rnd_data", 32'(r.d), 32'(rd));
         chk("a_rnd_ferr", 32'(r.fe), 32'(!rs));
      end

      for (int i = 0; i < 16; i++) begin
         rd7 = 7'($urandom);
         rp  = 1'($urandom);
         rs  = ($urandom_range(0, 3) != 0);
         drive_b(frame_b(rd7, rp, rs), 11);
         cyc(2 * BIT_B);
         chk("b_rnd_count", 32'(qb.size()), 32'd1);
         r = pop_b();
         chk("b_rnd_data", 32'(r.d), 32'(rd7));
         chk("b_rnd_perr", 32'(r.pe), 32'(even_perr(rd7, rp)));
         chk("b_rnd_ferr", 32'(r.fe), 32'(!rs));
      end

      // Three-tick glitch: start is detected, then rejected by the majority vote.
      rxa = 1'b0;
      cyc(6);
      chk("glitch_start", 32'(u_a.state_q), 32'(ST_START));
      rxa = 1'b1;
      cyc(2 * BIT_A);
      chk("glitch_idle", 32'(u_a.state_q), 32'(ST_IDLE));
      chk("glitch_none", 32'(qa.size()), 32'd0);

      // Overrun: hold 0x11, a second frame is dropped with a single pulse.
      rdya = 1'b0;
      o0 = a_ovr;
      drive_a(frame_a(8'h11, 1'b1), 10);
      cyc(BIT_A);
      chk("ovr_hold_valid", 32'(va), 32'd1);
      chk("ovr_hold_data", 32'(da), 32'h11);
      drive_a(frame_a(8'h22, 1'b1), 10);
      cyc(BIT_A);
      chk("ovr_kept_data", 32'(da), 32'h11);
      chk("ovr_kept_valid", 32'(va), 32'd1);
      chk("ovr_pulses", a_ovr - o0, 32'd1);

      // Reset mid-frame while 0x11 is still held: everything is discarded.
      rxa = 1'b0;
      cyc(BIT_A);
      rxa = 1'b1;
      cyc(BIT_A);
      rxa = 1'b0;
      cyc(BIT_A / 2);
      rst = 1'b1;
      cyc(1);
      chk("mid_rst_valid", 32'(va), 32'd0);
      chk("mid_rst_data", 32'(da), 32'd0);
      cyc(3);
      rxa = 1'b1;
      rst = 1'b0;
      cyc(12 * BIT_A);
      rdya = 1'b1;
      cyc(4);
      chk("mid_rst_none", 32'(qa.size()), 32'd0);

      // Line low for 12 bit times, then a normal frame.
      b0 = a_brk;
      rxa = 1'b0;
      cyc(12 * BIT_A);
      rxa = 1'b1;
      cyc(2 * BIT_A);
`ifdef UART_RX_BREAK_DET_EN
      chk("brk_pulses", a_brk - b0, 32'd1);
      chk("brk_no_valid", 32'(qa.size()), 32'd0);
`else
      chk("brk_tied", a_brk - b0, 32'd0);
      chk("brk_as_frame", 32'(qa.size()), 32'd1);
      r = pop_a();
      chk("brk_data", 32'(r.d), 32'd0);
      chk("brk_ferr", 32'(r.fe), 32'd1);
`endif
      drive_a(frame_a(8'h5A, 1'b1), 10);
      cyc(2 * BIT_A);
      chk("post_brk_count", 32'(qa.size()), 32'd1);
      r = pop_a();
      chk("post_brk_data", 32'(r.d), 32'h5A);
      chk("post_brk_ferr", 32'(r.fe), 32'd0);
      chk("b_no_events", b_ovr + b_brk, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
